// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver, 5-8 data bits, optional parity, 1/1.5/2 stop bits; UART_RX_MAJORITY_EN selects 3-sample majority voting.
// Latency: byte presented one cycle after the first stop-bit decision (one extra cycle with UART_RX_MAJORITY_EN).
// Backpressure: rx_data/rx_valid held until rx_ready; a frame completing while the held byte is unaccepted is dropped and sets rx_error.
module uart_frame_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] clk_div,
   input  logic        check_en,
   input  logic [1:0]  check_type,
   input  logic [1:0]  data_bit,
   input  logic [1:0]  stop_bit,
   input  logic        uart_rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        rx_busy,
   output logic        rx_error,
   input  logic        err_clr,
   output logic [15:0] rx_byte_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_HOLD
   } state_t;

   // Every bit decision is pushed one cycle later when voting, so the bit
   // spacing stays clk_div; only the first (start) decision needs the offset.
`ifdef UART_RX_MAJORITY_EN
   localparam logic [31:0] VOTE_LAT = 32'd1;
`else
   localparam logic [31:0] VOTE_LAT = 32'd0;
`endif

   // line synchronizer and edge detection
   logic        r_sync1;
   logic        r_sync2;
   logic        r_line_prev;

   // control
   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_cnt;
   logic [31:0] w_cnt_nxt;

   // configuration captured at the start edge
   logic [31:0] r_div;
   logic        r_chk_en;
   logic [1:0]  r_chk_type;
   logic [1:0]  r_dbits;
   logic [1:0]  r_stop;

   // frame assembly
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic        r_par_err;
   logic        r_dlv_pend;
   logic        r_dlv_bad;

   // output registers
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;
   logic        r_rx_error;
   logic [15:0] r_byte_cnt;

   // combinational strobes
   logic        w_fall;
   logic        w_bit;
   logic        w_start_go;
   logic        w_data_smp;
   logic        w_par_smp;
   logic        w_stop_smp;
   logic        w_hold_low;
   logic        w_par_exp;
   logic [31:0] w_start_tgt;
   logic [31:0] w_hold_len;
   logic [2:0]  w_last_idx;
   logic        w_load;
   logic        w_ovr;
   logic        w_err_set;

   // two-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_line_prev <= 1'b1;
      end else begin
         r_sync1     <= uart_rx;
         r_sync2     <= r_sync1;
         r_line_prev <= r_sync2;
      end
   end

   assign w_fall = r_line_prev & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] r_hist;

   // keep the two previous synchronized samples for the vote
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist <= 2'b11;
      end else begin
         r_hist <= {r_hist[0], r_sync2};
      end
   end

   // decision cycle is mid-bit+1: vote over mid-bit-1, mid-bit, mid-bit+1
   assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
`else
   assign w_bit = r_sync2;
`endif

   assign w_start_tgt = (r_div >> 1) + VOTE_LAT;
   assign w_hold_len  = (r_stop == 2'b01) ? (r_div >> 1) : r_div;
   assign w_last_idx  = 3'd4 + {1'b0, r_dbits};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state, bit-timer and sample strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 32'd1;
      w_start_go  = 1'b0;
      w_data_smp  = 1'b0;
      w_par_smp   = 1'b0;
      w_stop_smp  = 1'b0;
      w_hold_low  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 32'd1;
            if (w_fall) begin
               w_start_go  = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == w_start_tgt) begin
               w_cnt_nxt   = 32'd1;
               w_state_nxt = w_bit ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == r_div) begin
               w_cnt_nxt  = 32'd1;
               w_data_smp = 1'b1;
               if (r_bit_idx == w_last_idx) begin
                  w_state_nxt = r_chk_en ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (r_cnt == r_div) begin
               w_cnt_nxt   = 32'd1;
               w_par_smp   = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (r_cnt == r_div) begin
               w_cnt_nxt   = 32'd1;
               w_stop_smp  = 1'b1;
               w_state_nxt = (r_stop == 2'b00) ? S_IDLE : S_HOLD;
            end
         end
         S_HOLD: begin
            w_hold_low = ~r_sync2;
            if (r_cnt == w_hold_len) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // expected parity value for the received data bits (unused bits are 0)
   always_comb begin
      w_par_exp = 1'b0;
      case (r_chk_type)
         2'b00:   w_par_exp = ^r_shift;
         2'b01:   w_par_exp = ~^r_shift;
         2'b10:   w_par_exp = 1'b1;
         default: w_par_exp = 1'b0;
      endcase
   end

   // bit timer, configuration capture and frame assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 32'd1;
         r_div      <= 32'd4;
         r_chk_en   <= 1'b0;
         r_chk_type <= 2'b00;
         r_dbits    <= 2'b11;
         r_stop     <= 2'b00;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'h00;
         r_par_err  <= 1'b0;
         r_dlv_pend <= 1'b0;
         r_dlv_bad  <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_dlv_pend <= w_stop_smp;
         if (w_start_go) begin
            r_div      <= (clk_div < 32'd4) ? 32'd4 : clk_div;
            r_chk_en   <= check_en;
            r_chk_type <= check_type;
            r_dbits    <= data_bit;
            r_stop     <= stop_bit;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_err  <= 1'b0;
         end
         if (w_data_smp) begin
            r_shift[r_bit_idx] <= w_bit;
            r_bit_idx          <= r_bit_idx + 3'd1;
         end
         if (w_par_smp) begin
            r_par_err <= (w_bit != w_par_exp);
         end
         if (w_stop_smp) begin
            r_dlv_bad <= r_par_err | ~w_bit;
         end
      end
   end

   // delivery decision one cycle after the stop sample
   assign w_load    = r_dlv_pend & ~r_dlv_bad & ~(r_rx_valid & ~rx_ready);
   assign w_ovr     = r_dlv_pend & ~r_dlv_bad & r_rx_valid & ~rx_ready;
   assign w_err_set = (r_dlv_pend & r_dlv_bad) | w_ovr | w_hold_low;

   // output byte, handshake, frame counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_rx_error <= 1'b0;
         r_byte_cnt <= 16'h0000;
      end else begin
         if (w_load) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
            r_byte_cnt <= r_byte_cnt + 16'd1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (w_err_set) begin
            r_rx_error <= 1'b1;
         end else if (err_clr) begin
            r_rx_error <= 1'b0;
         end
      end
   end

   assign rx_data       = r_rx_data;
   assign rx_valid      = r_rx_valid;
   assign rx_error      = r_rx_error;
   assign rx_byte_count = r_byte_cnt;
   assign rx_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed and randomized frames against a frame-level reference model.
// Latency: n/a (bench).
// Backpressure: drives rx_ready high except for the overrun scenario.
`timescale 1ns/1ps
module tb_uart_frame_rx;

   logic        clk;
   logic        rst_n;
   logic [31:0] clk_div;
   logic        check_en;
   logic [1:0]  check_type;
   logic [1:0]  data_bit;
   logic [1:0]  stop_bit;
   logic        uart_rx;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rx_busy;
   logic        rx_error;
   logic        err_clr;
   logic [15:0] rx_byte_count;

   int n_checks;
   int n_errors;
   int n_hs;
   int n_vcyc;

   // reference model: bytes expected at the handshake, delivered count, sticky error, held byte
   logic [7:0] exp_q[$];
   int         m_cnt;
   bit         m_err;
   bit         m_pending;

   uart_frame_rx dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clk_div       (clk_div),
      .check_en      (check_en),
      .check_type    (check_type),
      .data_bit      (data_bit),
      .stop_bit      (stop_bit),
      .uart_rx       (uart_rx),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_busy       (rx_busy),
      .rx_error      (rx_error),
      .err_clr       (err_clr),
      .rx_byte_count (rx_byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // handshake monitor: every accepted byte must be the oldest expected one
   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         n_vcyc++;
         if (rx_ready) begin
            n_hs++;
            check("hs_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("hs_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic drive_bit(input bit b, input int n);
      uart_rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      m_err   = 1'b0;
      @(negedge clk);
      check("err_clr", {31'd0, rx_error}, {31'd0, m_err});
      @(posedge clk);
      #1;
   endtask

   // one frame: update the model from the frame's contents, send it, then compare
   task automatic run_frame(input logic [7:0] d, input logic [31:0] div_in, input logic [1:0] db,
                            input bit pen, input logic [1:0] ptype, input logic [1:0] sb,
                            input bit par_flip, input bit stop1_low, input bit stop2_low,
                            input string tag);
      int         div;
      int         nb;
      int         ones;
      int         hs0;
      int         vc0;
      int         exp_hs;
      logic [7:0] dm;
      bit         pexp;
      bit         good;
      bit         errs;
      div  = (div_in < 32'd4) ? 4 : int'(div_in);
      nb   = 5 + int'(db);
      dm   = 8'h00;
      ones = 0;
      for (int i = 0; i < nb; i++) begin
         dm[i] = d[i];
         ones += int'(d[i]);
      end
      case (ptype)
         2'b00:   pexp = (ones % 2) == 1;
         2'b01:   pexp = (ones % 2) == 0;
         2'b10:   pexp = 1'b1;
         default: pexp = 1'b0;
      endcase
      good   = !(pen && par_flip) && !stop1_low;
      errs   = !good || ((sb >= 2'd2) && stop2_low);
      exp_hs = 0;
      if (good) begin
         if (m_pending) begin
            errs = 1'b1;
         end else begin
            exp_q.push_back(dm);
            m_cnt++;
            if (rx_ready) exp_hs = 1;
            else m_pending = 1'b1;
         end
      end
      m_err = m_err | errs;

      clk_div    = div_in;
      data_bit   = db;
      check_en   = pen;
      check_type = ptype;
      stop_bit   = sb;
      hs0 = n_hs;
      vc0 = n_vcyc;

      drive_bit(1'b0, div);
      // configuration already captured; disturb it for the rest of the frame
      clk_div    = $urandom_range(0, 64);
      data_bit   = 2'($urandom);
      check_en   = 1'($urandom);
      check_type = 2'($urandom);
      stop_bit   = 2'($urandom);
      for (int i = 0; i < nb; i++) drive_bit(d[i], div);
      if (pen) drive_bit(pexp ^ par_flip, div);
      drive_bit(!stop1_low, div);
      if (sb == 2'b01) drive_bit(1'b1, div / 2);
      else if (sb >= 2'd2) drive_bit(!stop2_low, div);
      drive_bit(1'b1, 2 * div + 6);

      @(negedge clk);
      check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
      check({tag, "_err"}, {31'd0, rx_error}, {31'd0, m_err});
      check({tag, "_cnt"}, {16'd0, rx_byte_count}, 32'(m_cnt & 16'hFFFF));
      check({tag, "_hs"}, 32'(n_hs - hs0), 32'(exp_hs));
      if (rx_ready) check({tag, "_vcyc"}, 32'(n_vcyc - vc0), 32'(exp_hs));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int         hs0;
      logic [7:0] rd;
      n_checks   = 0;
      n_errors   = 0;
      n_hs       = 0;
      n_vcyc     = 0;
      m_cnt      = 0;
      m_err      = 1'b0;
      m_pending  = 1'b0;
      rst_n      = 1'b0;
      uart_rx    = 1'b1;
      rx_ready   = 1'b1;
      err_clr    = 1'b0;
      clk_div    = 32'd16;
      check_en   = 1'b0;
      check_type = 2'b00;
      data_bit   = 2'b11;
      stop_bit   = 2'b00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy", {31'd0, rx_busy}, 32'd0);
      check("rst_err", {31'd0, rx_error}, 32'd0);
      check("rst_cnt", {16'd0, rx_byte_count}, 32'd0);
      check("rst_data", {24'd0, rx_data}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // 8N1 0xA5
      run_frame(8'hA5, 32'd16, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "a5");

      // 7E1 0x35 with wrong parity
      run_frame(8'h35, 32'd16, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "par");
      pulse_clr();

      // glitch: line low for only 4 cycles
      clk_div = 32'd16;
      hs0     = n_hs;
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 4);
      @(negedge clk);
      check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
      check("glitch_err", {31'd0, rx_error}, 32'd0);
      check("glitch_cnt", {16'd0, rx_byte_count}, 32'(m_cnt));
      check("glitch_hs", 32'(n_hs - hs0), 32'd0);
      @(posedge clk);
      #1;

      // overrun: two frames with rx_ready low
      rx_ready = 1'b0;
      run_frame(8'h11, 32'd16, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "ovr1");
      run_frame(8'h22, 32'd16, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "ovr2");
      @(negedge clk);
      rd = rx_data;
      check("ovr_data", {24'd0, rd}, 32'h11);
      check("ovr_valid", {31'd0, rx_valid}, 32'd1);
      @(posedge clk);
      #1;
      hs0       = n_hs;
      rx_ready  = 1'b1;
      m_pending = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ovr_hs", 32'(n_hs - hs0), 32'd1);
      check("ovr_valid_lo", {31'd0, rx_valid}, 32'd0);
      @(posedge clk);
      #1;
      pulse_clr();

      // 5N2 0x1F, second stop bit low: byte delivered, then error
      run_frame(8'h1F, 32'd16, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, "stop2");
      pulse_clr();

      // reset in the middle of the data phase
      clk_div  = 32'd16;
      data_bit = 2'b11;
      check_en = 1'b0;
      stop_bit = 2'b00;
      drive_bit(1'b0, 16 + 40);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
      check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
      check("mid_rst_data", {24'd0, rx_data}, 32'd0);
      check("mid_rst_cnt", {16'd0, rx_byte_count}, 32'd0);
      check("mid_rst_err", {31'd0, rx_error}, 32'd0);
      uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      m_cnt     = 0;
      m_err     = 1'b0;
      m_pending = 1'b0;
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      run_frame(8'h5A, 32'd16, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "after_rst");

      // randomized frames, including clk_div values below the minimum
      for (int k = 0; k < 30; k++) begin
         logic [31:0] dv;
         logic [1:0]  db;
         logic [1:0]  pt;
         logic [1:0]  sb;
         bit          pen;
         int          c;
         dv  = $urandom_range(0, 20);
         db  = 2'($urandom);
         pt  = 2'($urandom);
         sb  = 2'($urandom);
         pen = 1'($urandom);
         c   = $urandom_range(0, 9);
         run_frame(8'($urandom), dv, db, pen, pt, sb,
                   (c == 0) && pen, (c == 1), (c == 2) && (sb >= 2'd2), "rnd");
         if (m_err) pulse_clr();
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have ports clk (input, 1, system clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 SHALL have clk_div (input, 32, clocks per bit; values below 4 treated as 4).
REQ-003 SHALL have check_en (input, 1, 1 = parity bit present) and check_type (input, 2; 00 even, 01 odd, 10 mark, 11 space).
REQ-004 SHALL have data_bit (input, 2; 00/01/10/11 = 5/6/7/8 bits) and stop_bit (input, 2; 00 = 1, 01 = 1.5, 10/11 = 2).
REQ-005 SHALL have uart_rx (input, 1, serial line, idle high, asynchronous).
REQ-006 SHALL have rx_data (output, 8), rx_valid (output, 1) and rx_ready (input, 1), forming a valid/ready handshake.
REQ-007 SHALL have rx_busy (output, 1, frame in progress), rx_error (output, 1, sticky error), err_clr (input, 1, clears rx_error) and rx_byte_count (output, 16, delivered frames).

Function
REQ-008 SHALL pass uart_rx through a 2-flop synchronizer; all line decisions use the synchronized value.
REQ-009 SHALL implement states IDLE, START, DATA, PARITY, STOP, HOLD.
- In IDLE, a synchronized high-to-low transition moves to START; rx_busy is 1 in every state except IDLE.
REQ-010 SHALL, in START, sample the line after (clk_div>>1) cycles.
- Line high means false start: return to IDLE, no error, no count.
- Line low: move to DATA.
REQ-011 SHALL, in DATA, sample every clk_div cycles, LSB first, for 5..8 bits per data_bit; unused upper bits of rx_data are 0.
REQ-012 SHALL go to PARITY only when check_en=1, sampling one bit clk_div cycles after the last data bit.
- Expected value: even = XOR of data bits; odd = its inverse; mark = 1; space = 0.
- Mismatch flags a parity error.
REQ-013 SHALL, in STOP, sample the first stop bit clk_div cycles after the previous sample; a low sample flags a framing error.
REQ-014 SHALL, one cycle after the stop sample on an error-free frame, load rx_data, assert rx_valid and increment rx_byte_count.
- rx_byte_count wraps 0xFFFF to 0x0000.
REQ-015 SHALL hold rx_data and rx_valid stable until a cycle with rx_valid=1 and rx_ready=1; rx_valid deasserts the next cycle.
REQ-016 SHALL, on overrun (frame completes while rx_valid=1 and not accepted in that cycle):
- keep the old byte;
- discard the new byte;
- set rx_error;
- leave rx_byte_count unchanged.
REQ-017 SHALL discard the byte and set rx_error on a parity or framing error; rx_valid is not asserted.
REQ-018 SHALL, after the stop sample, enter HOLD for 0 (1 stop), clk_div>>1 (1.5 stop) or clk_div (2 stop) cycles.
- Line low during HOLD sets rx_error; the byte already delivered is not retracted.
- HOLD then returns to IDLE.
REQ-019 SHALL clear rx_error on err_clr=1; a new error in the same cycle takes priority, so rx_error stays 1.
REQ-020 SHALL latch the configuration inputs at the start-bit edge; changes mid-frame take effect on the next frame.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-frame:
- enter IDLE;
- set rx_data=0x00, rx_valid=0, rx_busy=0, rx_error=0, rx_byte_count=0;
- set the synchronizer flops to 1.

Configuration
REQ-022 SHALL support macro UART_RX_MAJORITY_EN, selecting how each bit (start/data/parity/stop) is sampled.
- Defined: each bit is decided by majority vote of 3 samples at mid-bit-1, mid-bit and mid-bit+1 cycles. The START check uses the same vote, and delivery latency grows by 1 cycle.
- Undefined: each bit is a single sample at mid-bit.

Verification
REQ-023 clk_div=16, 8N1, frame 0xA5, rx_ready=1 -> rx_valid for exactly 1 cycle, rx_data=0xA5, rx_byte_count=1, rx_error=0.
REQ-024 clk_div=16, 7E1, data 0x35 sent with parity bit 1 (expected 0) -> no rx_valid, rx_error=1; err_clr pulse -> rx_error=0.
REQ-025 Line low for 4 cycles at clk_div=16 -> no rx_valid, rx_busy returns to 0, rx_byte_count unchanged, rx_error=0.
REQ-026 rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, rx_error=1, rx_byte_count=1; rx_ready=1 -> one handshake, data 0x11.
REQ-027 5N2, data 0x1F, second stop bit driven low -> rx_data=0x1F delivered, then rx_error=1.
REQ-028 rst_n pulsed low mid DATA phase, then frame 0x5A sent -> all outputs at reset values; 0x5A received, rx_byte_count=1.
